alu_multibyte_seq: RTL and testbench

//  Sequencer that runs NBYTES-wide arithmetic/logic operations on the shared 8-bit Alu, one byte per cycle.
//  It works LSB first and chains the carry/borrow through the Alu cin/cout.
//  It sits between the datapath control (start/op/operands) and the Alu instance, and drives all Alu inputs.
//  It accumulates the result, final carry and a whole-word zero flag.

---
 rtl/alu_multibyte_seq.sv | 170 +++++++++++++++++
 tb/tb_alu_multibyte_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multibyte_seq.sv
// alu_multibyte_seq: runs NBYTES-wide ALU operations on a shared 8-bit Alu.
// Each RUN cycle processes one byte, starting with the least significant byte.
// The carry/borrow is chained through alu_cin/alu_cout.
// The word result, the final carry and a whole-word zero flag are accumulated
// and presented with a one-cycle done pulse.
// Function codes: ADD=0 ADDC=1 SUB=2 SUBC=3 AND=4 OR=5 XOR=6 MASK=7.
module alu_multibyte_seq #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic                  cin,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout,
  output logic                  zero,
  output logic [7:0]            alu_in1,
  output logic [7:0]            alu_in2,
  output logic                  alu_cin,
  output logic [2:0]            alu_op,
  input  logic [7:0]            alu_out,
  input  logic                  alu_cout,
  input  logic                  alu_z
);

  localparam int unsigned W    = 8 * NBYTES;
  localparam int unsigned IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [2:0] ADD_FN  = 3'd0;
  localparam logic [2:0] ADDC_FN = 3'd1;
  localparam logic [2:0] SUB_FN  = 3'd2;
  localparam logic [2:0] SUBC_FN = 3'd3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [2:0]      op_q, op_d;
  logic            carry_q, carry_d;
  logic            zacc_q, zacc_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q, cout_d;
  logic            zero_q, zero_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            op_is_arith;

  assign op_is_arith = (op_q == ADD_FN) || (op_q == ADDC_FN) ||
                       (op_q == SUB_FN) || (op_q == SUBC_FN);

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = zero_q;

  // Alu drive: the current byte in RUN, a quiet ADD of zeros otherwise
  always_comb begin
    alu_in1 = '0;
    alu_in2 = '0;
    alu_cin = 1'b0;
    alu_op  = ADD_FN;
    if (state_q == RUN) begin
      alu_in1 = a_q[8*idx_q +: 8];
      alu_in2 = b_q[8*idx_q +: 8];
      alu_cin = carry_q;
      // Arithmetic always uses the carry-in form; byte 0 of plain ADD/SUB
      // starts with carry_q cleared, so every byte follows the same chain.
      case (op_q)
        ADD_FN, ADDC_FN: alu_op = ADDC_FN;
        SUB_FN, SUBC_FN: alu_op = SUBC_FN;
        default:         alu_op = op_q;
      endcase
    end
  end

  // Next-state and datapath capture for the IDLE -> RUN -> DONE sequence
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    carry_d  = carry_q;
    zacc_d   = zacc_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          carry_d = ((op == ADDC_FN) || (op == SUBC_FN)) ? cin : 1'b0;
          zacc_d  = 1'b1;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[8*idx_q +: 8] = alu_out;
        carry_d = op_is_arith ? alu_cout : 1'b0;
        zacc_d  = zacc_q & alu_z;
        if (idx_q == IDXW'(NBYTES - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          cout_d  = carry_d;
          zero_d  = zacc_d;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d == RUN);
  end

  // State register with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      zacc_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      zacc_q   <= zacc_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_alu_multibyte_seq.sv
// Bench for alu_multibyte_seq: a behavioural byte Alu is attached to each DUT.
// Results are checked against word-level arithmetic on the whole operands.
module tb_alu_multibyte_seq;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  localparam logic [2:0] ADD_FN  = 3'd0;
  localparam logic [2:0] ADDC_FN = 3'd1;
  localparam logic [2:0] SUB_FN  = 3'd2;
  localparam logic [2:0] SUBC_FN = 3'd3;
  localparam logic [2:0] AND_FN  = 3'd4;
  localparam logic [2:0] OR_FN   = 3'd5;
  localparam logic [2:0] XOR_FN  = 3'd6;
  localparam logic [2:0] MASK_FN = 3'd7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // NBYTES=4 instance
  logic         start, cin, ready, busy, done, cout, zero;
  logic [2:0]   op;
  logic [W-1:0] a, b, result;
  logic [7:0]   alu_in1, alu_in2, alu_out;
  logic         alu_cin, alu_cout, alu_z;
  logic [2:0]   alu_op;
  logic [9:0]   alu_resp;

  // NBYTES=1 instance
  logic         start1, cin1, ready1, busy1, done1, cout1, zero1;
  logic [2:0]   op1;
  logic [7:0]   a1, b1, result1;
  logic [7:0]   alu1_in1, alu1_in2, alu1_out;
  logic         alu1_cin, alu1_cout, alu1_z;
  logic [2:0]   alu1_op;
  logic [9:0]   alu1_resp;

  int n_assert = 0;
  int n_fail   = 0;

  // Byte Alu: returns {z, cout, out}; subtract cout is the borrow
  function automatic logic [9:0] alu_model(input logic [2:0] o, input logic [7:0] x,
                                           input logic [7:0] y, input logic c);
    logic [8:0] s;
    case (o)
      ADD_FN:  s = {1'b0, x} + {1'b0, y};
      ADDC_FN: s = {1'b0, x} + {1'b0, y} + 9'(c);
      SUB_FN:  s = {1'b0, x} - {1'b0, y};
      SUBC_FN: s = {1'b0, x} - {1'b0, y} - 9'(c);
      AND_FN:  s = {1'b0, x & y};
      OR_FN:   s = {1'b0, x | y};
      XOR_FN:  s = {1'b0, x ^ y};
      default: s = {1'b0, ~x & y};
    endcase
    return {(s[7:0] == 8'h00), s};
  endfunction

  // Whole-word reference: returns {cout/borrow, result}
  function automatic logic [W:0] ref_word(input logic [2:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y, input logic c);
    case (o)
      ADD_FN:  return {1'b0, x} + {1'b0, y};
      ADDC_FN: return {1'b0, x} + {1'b0, y} + (W+1)'(c);
      SUB_FN:  return {1'b0, x} - {1'b0, y};
      SUBC_FN: return {1'b0, x} - {1'b0, y} - (W+1)'(c);
      AND_FN:  return {1'b0, x & y};
      OR_FN:   return {1'b0, x | y};
      XOR_FN:  return {1'b0, x ^ y};
      default: return {1'b0, ~x & y};
    endcase
  endfunction

  assign alu_resp  = alu_model(alu_op, alu_in1, alu_in2, alu_cin);
  assign alu_out   = alu_resp[7:0];
  assign alu_cout  = alu_resp[8];
  assign alu_z     = alu_resp[9];
  assign alu1_resp = alu_model(alu1_op, alu1_in1, alu1_in2, alu1_cin);
  assign alu1_out  = alu1_resp[7:0];
  assign alu1_cout = alu1_resp[8];
  assign alu1_z    = alu1_resp[9];

  alu_multibyte_seq #(.NBYTES(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .cin(cin), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_out(alu_out), .alu_cout(alu_cout), .alu_z(alu_z)
  );

  alu_multibyte_seq #(.NBYTES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op(op1), .cin(cin1), .a(a1), .b(b1),
    .ready(ready1), .busy(busy1), .done(done1), .result(result1), .cout(cout1), .zero(zero1),
    .alu_in1(alu1_in1), .alu_in2(alu1_in2), .alu_cin(alu1_cin), .alu_op(alu1_op),
    .alu_out(alu1_out), .alu_cout(alu1_cout), .alu_z(alu1_z)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation on the 4-byte DUT; cycle 0 is the cycle where start is accepted
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, input string tag,
                       output logic [W-1:0] r_obs, output logic c_obs, output logic z_obs);
    logic [W:0] exp;
    int n;
    exp = ref_word(o, x, y, c);
    @(negedge clk);
    op = o; a = x; b = y; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    n = 0;
    while (n < 20 && !done) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n + 1), 64'(NB + 1));
    check({tag, "_result"}, 64'(result), 64'(exp[W-1:0]));
    check({tag, "_cout"}, 64'(cout), 64'(exp[W]));
    check({tag, "_zero"}, 64'(zero), 64'(exp[W-1:0] == '0));
    r_obs = result; c_obs = cout; z_obs = zero;
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_ready_after"}, 64'(ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] r;
    logic         co, zo;
    logic [W-1:0] held;
    int           dones, n;
    logic [2:0]   ro;
    logic [W-1:0] rx, ry;

    rst = 1'b1; start = 1'b0; op = '0; cin = 1'b0; a = '0; b = '0;
    start1 = 1'b0; op1 = '0; cin1 = 1'b0; a1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    check("idle_alu_op", 64'(alu_op), 64'(ADD_FN));
    check("idle_alu_drive", 64'({alu_in1, alu_in2, alu_cin}), 64'd0);

    // Directed vectors, also compared with literal values
    do_op(ADD_FN, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "add_wrap", r, co, zo);
    check("add_wrap_lit", 64'({r, co, zo}), 64'({32'h0, 1'b1, 1'b1}));
    do_op(SUB_FN, 32'h0000_0000, 32'h0000_0001, 1'b0, "sub_borrow", r, co, zo);
    check("sub_borrow_lit", 64'({r, co, zo}), 64'({32'hFFFF_FFFF, 1'b1, 1'b0}));
    do_op(SUB_FN, 32'h0000_0100, 32'h0000_0001, 1'b0, "sub_ripple", r, co, zo);
    check("sub_ripple_lit", 64'({r, co}), 64'({32'h0000_00FF, 1'b0}));
    do_op(ADDC_FN, 32'h0000_00FF, 32'h0, 1'b1, "addc_cin", r, co, zo);
    check("addc_cin_lit", 64'({r, co}), 64'({32'h0000_0100, 1'b0}));
    do_op(ADD_FN, 32'h0000_00FF, 32'h0, 1'b1, "add_ign_cin", r, co, zo);
    check("add_ign_cin_lit", 64'(r), 64'h0000_00FF);
    do_op(SUBC_FN, 32'h0000_0000, 32'h0, 1'b1, "subc_bin", r, co, zo);
    check("subc_bin_lit", 64'({r, co}), 64'({32'hFFFF_FFFF, 1'b1}));
    do_op(MASK_FN, 32'hFFFF_0000, 32'hFFFF_FFFF, 1'b1, "mask", r, co, zo);
    check("mask_lit", 64'({r, co}), 64'({32'h0000_FFFF, 1'b0}));
    do_op(XOR_FN, 32'h1234_5678, 32'h1234_5678, 1'b0, "xor_zero", r, co, zo);
    check("xor_zero_lit", 64'({r, zo}), 64'({32'h0, 1'b1}));

    // start held high on every RUN and DONE cycle with other operands
    @(negedge clk);
    op = ADD_FN; a = 32'h1111_1111; b = 32'h2222_2222; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    dones = 0;
    held = '0;
    for (int k = 0; k < NB + 1; k++) begin
      @(negedge clk);
      start = 1'b1; op = SUB_FN; a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      if (done) begin
        dones++;
        held = result;
      end
    end
    @(negedge clk); start = 1'b0;
    check("ign_start_dones", 64'(dones), 64'd1);
    check("ign_start_result", 64'(held), 64'h3333_3333);
    check("ign_start_idle", 64'({ready, busy}), 64'b10);

    // Outputs stay put in IDLE while inputs wander
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); a = W'($urandom); b = W'($urandom); op = 3'($urandom);
      @(posedge clk); #1;
      check("idle_hold", 64'({result, cout, zero}), 64'({32'h3333_3333, 1'b0, 1'b0}));
    end

    // Reset while byte 2 is in flight
    @(negedge clk);
    op = OR_FN; a = 32'hA5A5_A5A5; b = 32'h0F0F_0F0F; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    @(negedge clk); rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);

    // Single-byte instance behaves as a registered Alu op
    @(negedge clk);
    op1 = ADD_FN; a1 = 8'hFF; b1 = 8'h01; cin1 = 1'b0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    n = 0;
    while (n < 20 && !done1) begin
      @(posedge clk); #1;
      n++;
    end
    check("nb1_latency", 64'(n + 1), 64'd2);
    check("nb1_result", 64'({result1, cout1, zero1}), 64'({8'h00, 1'b1, 1'b1}));

    // Randomized operations checked against the word reference
    for (int k = 0; k < 40; k++) begin
      ro = 3'($urandom_range(0, 7));
      rx = W'($urandom);
      ry = (k % 5 == 0) ? rx : W'($urandom);
      if (k % 7 == 0) ry = ~rx;
      do_op(ro, rx, ry, 1'($urandom_range(0, 1)), "rand", r, co, zo);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
